// File: rtl/coreir_stream_pkg.sv
// Shared helpers for the coreir streaming blocks.
//   clog2_min1(n)          : ceil(log2(n)), never less than 1 bit
//   num_slices(w, c)       : number of c-bit slices in a w-bit word
//   idx_width(w, c)        : width of a counter that addresses those slices
package coreir_stream_pkg;

    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Guarded against chunk == 0 so a bad parameter reaches the module's
    // own elaboration check instead of a divide-by-zero.
    function automatic int num_slices(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    function automatic int idx_width(input int width, input int chunk);
        return clog2_min1(num_slices(width, chunk));
    endfunction

endpackage

// File: rtl/coreir_unpack.sv
// Streaming unpacker: takes one width-bit word per ready/valid handshake and
// emits it LSB-first as width/chunk slices of chunk bits each.
//
// Ports
//   clk        rising-edge clock
//   arst       asynchronous reset, active-high
//   in_data    word to unpack (sampled only when accepted)
//   in_valid   in_data is valid
//   in_ready   a word can be accepted this cycle
//   out_data   current slice
//   out_valid  out_data is valid
//   out_ready  consumer takes the slice this cycle
//   out_last   current slice is the most-significant slice of its word
module coreir_unpack
    import coreir_stream_pkg::*;
#(
    parameter int width = 16,
    parameter int chunk = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [width-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [chunk-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    localparam int N     = num_slices(width, chunk);
    localparam int IDX_W = idx_width(width, chunk);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if ((chunk < 1) || (chunk > width) || ((width % chunk) != 0)) begin : g_bad_params
        $error("coreir_unpack: width must be a positive integer multiple of chunk");
    end

    logic [width-1:0] hold;
    logic [IDX_W-1:0] idx;
    logic             busy;
    logic             accept;
    logic             xfer;

    assign out_valid = busy;
    assign out_last  = busy && (idx == LAST_IDX);
    // A new word may enter in the same cycle the last slice leaves, which
    // keeps the output side at one slice per cycle across word boundaries.
    assign in_ready  = !busy || (out_last && out_ready);
    assign accept    = in_valid && in_ready;
    assign xfer      = busy && out_ready;

    // Slice select is a mux over constant part-selects; hold never shifts,
    // so out_data stays stable under backpressure without extra logic.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IDX_W'(i)) begin
                out_data = hold[i*chunk +: chunk];
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            hold <= '0;
            idx  <= '0;
            busy <= 1'b0;
        end else if (accept) begin
            // Covers both the idle case and the back-to-back reload after
            // the last slice of the previous word.
            hold <= in_data;
            idx  <= '0;
            busy <= 1'b1;
        end else if (xfer) begin
            if (idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end else begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_coreir_unpack.sv
module tb_coreir_unpack;

    logic        clk;
    logic        arst;

    logic [15:0] a_in_data;
    logic        a_in_valid, a_in_ready;
    logic [3:0]  a_out_data;
    logic        a_out_valid, a_out_ready, a_out_last;

    logic [7:0]  b_in_data;
    logic        b_in_valid, b_in_ready;
    logic [7:0]  b_out_data;
    logic        b_out_valid, b_out_ready, b_out_last;

    coreir_unpack #(.width(16), .chunk(4)) u_a (
        .clk(clk), .arst(arst),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_last(a_out_last)
    );

    coreir_unpack #(.width(8), .chunk(8)) u_b (
        .clk(clk), .arst(arst),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_last(b_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the slices still owed to the consumer, in order,
    // plus the words accepted but not yet reassembled.
    int exp_d[$];
    bit exp_l[$];
    int wq[$];
    int pk_acc;
    int pk_pos;
    int words_done;
    bit sel;  // 0: 16/4 instance, 1: 8/8 instance

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        exp_d.delete();
        exp_l.delete();
        wq.delete();
        pk_acc = 0;
        pk_pos = 0;
    endtask

    // One clock cycle: drive at the falling edge, observe, predict what the
    // next rising edge does, and update the model accordingly.
    task automatic cycle(input bit v, input logic [15:0] d, input bit ordy,
                         output bit acc, output int xd);
        int n, c, word;
        logic        ov, ol, ir;
        logic [15:0] od;
        bit          exp_ir, xfer;
        n = sel ? 1 : 4;
        c = sel ? 8 : 4;
        @(negedge clk);
        a_in_valid  = sel ? 1'b0 : v;
        a_in_data   = d;
        a_out_ready = sel ? 1'b0 : ordy;
        b_in_valid  = sel ? v : 1'b0;
        b_in_data   = d[7:0];
        b_out_ready = sel ? ordy : 1'b0;
        #1;
        ov = sel ? b_out_valid : a_out_valid;
        ol = sel ? b_out_last  : a_out_last;
        ir = sel ? b_in_ready  : a_in_ready;
        od = sel ? {8'h00, b_out_data} : {12'h000, a_out_data};
        exp_ir = (exp_d.size() == 0) || (exp_d.size() == 1 && ordy);
        check("out_valid", ov, exp_d.size() != 0);
        check("in_ready", ir, exp_ir);
        if (exp_d.size() != 0) begin
            check("out_data", od, exp_d[0]);
            check("out_last", ol, exp_l[0]);
        end else begin
            check("out_last_idle", ol, 0);
        end
        xfer = (exp_d.size() != 0) && ordy;
        acc  = v && exp_ir;
        xd   = -1;
        if (xfer) begin
            xd = int'(od);
            // Behavioural packer: reassemble the DUT's own slices.
            pk_acc = pk_acc | (int'(od) << (pk_pos * c));
            pk_pos++;
            if (ol) begin
                if (wq.size() != 0) begin
                    check("loopback", pk_acc, wq.pop_front());
                    words_done++;
                end else begin
                    check("loopback_extra", 1, 0);
                end
                pk_acc = 0;
                pk_pos = 0;
            end
            void'(exp_d.pop_front());
            void'(exp_l.pop_front());
        end
        if (acc) begin
            word = sel ? int'(d[7:0]) : int'(d);
            wq.push_back(word);
            for (int i = 0; i < n; i++) begin
                exp_d.push_back((word >> (i * c)) & ((1 << c) - 1));
                exp_l.push_back(i == n - 1);
            end
        end
    endtask

    // Asynchronous reset pulse entirely between two rising edges.
    task automatic pulse_reset();
        @(negedge clk);
        a_in_valid = 0; a_out_ready = 0;
        b_in_valid = 0; b_out_ready = 0;
        #2 arst = 1'b1;
        #1;
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_a_out_last", a_out_last, 0);
        check("rst_a_out_data", a_out_data, 0);
        check("rst_b_out_valid", b_out_valid, 0);
        check("rst_b_in_ready", b_in_ready, 1);
        #1 arst = 1'b0;
        clear_model();
    endtask

    int log4[$];
    int exp4[8] = '{4, 3, 2, 1, 15, 14, 14, 11};

    initial begin
        bit acc;
        int xd, iters, target, cyc;
        a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
        sel = 0;
        words_done = 0;
        clear_model();
        arst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("init_out_valid", a_out_valid, 0);
        check("init_in_ready", a_in_ready, 1);
        check("init_out_data", a_out_data, 0);
        arst = 1'b0;

        // Basic word, consumer always ready.
        cycle(1, 16'hA5C3, 1, acc, xd);
        check("basic_accept", acc, 1);
        repeat (5) cycle(0, 16'h0, 1, acc, xd);

        // Backpressure during slice 1.
        cycle(1, 16'hA5C3, 1, acc, xd);
        cycle(0, 16'h0, 1, acc, xd);
        repeat (3) cycle(0, 16'h0, 0, acc, xd);
        repeat (4) cycle(0, 16'h0, 1, acc, xd);
        check("bp_all_words_done", words_done, 2);

        // Back-to-back words with in_valid held.
        log4.delete();
        cycle(1, 16'h1234, 1, acc, xd);
        check("b2b_first_accept", acc, 1);
        iters = 0;
        acc = 0;
        while (!acc && iters < 20) begin
            cycle(1, 16'hBEEF, 1, acc, xd);
            if (xd >= 0) log4.push_back(xd);
            iters++;
        end
        check("b2b_accept_cycle", iters, 4);
        repeat (4) begin
            cycle(0, 16'h0, 1, acc, xd);
            if (xd >= 0) log4.push_back(xd);
        end
        check("b2b_count", log4.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("b2b_slice", (i < log4.size()) ? log4[i] : -1, exp4[i]);
        end

        // Reset mid-word: two slices out, then the rest is discarded.
        cycle(1, 16'h1234, 1, acc, xd);
        cycle(0, 16'h0, 1, acc, xd);
        cycle(0, 16'h0, 1, acc, xd);
        pulse_reset();
        repeat (3) cycle(0, 16'h0, 1, acc, xd);
        log4.delete();
        cycle(1, 16'h00FF, 1, acc, xd);
        repeat (5) begin
            cycle(0, 16'h0, 1, acc, xd);
            if (xd >= 0) log4.push_back(xd);
        end
        check("rst_next_count", log4.size(), 4);
        if (log4.size() == 4) begin
            check("rst_next_s0", log4[0], 15);
            check("rst_next_s1", log4[1], 15);
            check("rst_next_s2", log4[2], 0);
            check("rst_next_s3", log4[3], 0);
        end

        // Random loopback on both configurations.
        for (int s = 0; s < 2; s++) begin
            pulse_reset();
            sel = (s == 1);
            words_done = 0;
            target = sel ? 200 : 1000;
            cyc = 0;
            while (words_done < target && cyc < 20000) begin
                cycle(($urandom_range(0, 3) != 0), 16'($urandom),
                      ($urandom_range(0, 3) != 0), acc, xd);
                cyc++;
            end
            check("rand_budget", (cyc < 20000), 1);
            repeat (6) cycle(0, 16'h0, 1, acc, xd);
            check("rand_drained", exp_d.size(), 0);
            check("rand_words_pending", wq.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
